// File: rtl/lab03_pkg.sv
// Shared types and defaults for the lab 3 bit-pair serializer.
// The LAB03_PAIR_PARITY_EN option is handled in the top module; nothing here depends on it.
package lab03_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lab03_state_e;

    localparam int LAB03_WIDTH      = 4;
    localparam int LAB03_BIT_CYCLES = 1;

    // A counter must keep at least one bit, even when it only ever holds zero.
    function automatic int lab03_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lab03_bit_timer.sv
// Period counter for the serializer.
// It counts 0..BIT_CYCLES-1 while enabled and flags the terminal count.
module lab03_bit_timer
    import lab03_pkg::*;
#(
    parameter int BIT_CYCLES = LAB03_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = lab03_cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] TC_VAL = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] periodCnt_q;
    logic [CW-1:0] periodCnt_d;

    assign tc = en && (periodCnt_q == TC_VAL);

    always_comb begin
        periodCnt_d = periodCnt_q;
        if (clr) begin
            periodCnt_d = '0;
        end else if (en) begin
            periodCnt_d = tc ? '0 : periodCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periodCnt_q <= '0;
        end else begin
            periodCnt_q <= periodCnt_d;
        end
    end

endmodule

// File: rtl/lab03_pair_serializer.sv
// Loads an A/B operand pair and shifts it out LSB-first as simultaneous bit pairs.
// Defining LAB03_PAIR_PARITY_EN appends an even-parity bit period and a parity_bit port.
module lab03_pair_serializer
    import lab03_pkg::*;
#(
    parameter int WIDTH      = LAB03_WIDTH,
    parameter int BIT_CYCLES = LAB03_BIT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_out,
    output logic             b_out,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic             done
`ifdef LAB03_PAIR_PARITY_EN
    ,
    output logic             parity_bit
`endif
);

    localparam int BW = lab03_cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    lab03_state_e     state_q;
    lab03_state_e     state_d;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] aShift_d;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-1:0] bShift_d;
    logic [BW-1:0]    bitCnt_q;
    logic [BW-1:0]    bitCnt_d;
    logic             loadFire;
    logic             periodTc;

`ifdef LAB03_PAIR_PARITY_EN
    logic             parPhase_q;
    logic             parPhase_d;
    logic             aPar_q;
    logic             aPar_d;
    logic             bPar_q;
    logic             bPar_d;
`endif

    assign loadFire = (state_q == IDLE) && load_valid;

    lab03_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (loadFire),
        .en  (state_q == SHIFT),
        .tc  (periodTc)
    );

    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        bitCnt_d = bitCnt_q;
`ifdef LAB03_PAIR_PARITY_EN
        parPhase_d = parPhase_q;
        aPar_d     = aPar_q;
        bPar_d     = bPar_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    aShift_d = a_in;
                    bShift_d = b_in;
                    bitCnt_d = '0;
                    state_d  = SHIFT;
`ifdef LAB03_PAIR_PARITY_EN
                    // Parity is taken from the captured operands, before any shifting.
                    aPar_d     = ^a_in;
                    bPar_d     = ^b_in;
                    parPhase_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (periodTc) begin
`ifdef LAB03_PAIR_PARITY_EN
                    if (parPhase_q) begin
                        parPhase_d = 1'b0;
                        bitCnt_d   = '0;
                        state_d    = DONE;
                    end else if (bitCnt_q == LAST_IDX) begin
                        parPhase_d = 1'b1;
                    end else begin
                        aShift_d = {1'b0, aShift_q[WIDTH-1:1]};
                        bShift_d = {1'b0, bShift_q[WIDTH-1:1]};
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
`else
                    if (bitCnt_q == LAST_IDX) begin
                        bitCnt_d = '0;
                        state_d  = DONE;
                    end else begin
                        aShift_d = {1'b0, aShift_q[WIDTH-1:1]};
                        bShift_d = {1'b0, bShift_q[WIDTH-1:1]};
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            bitCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            bitCnt_q <= bitCnt_d;
        end
    end

`ifdef LAB03_PAIR_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parPhase_q <= 1'b0;
            aPar_q     <= 1'b0;
            bPar_q     <= 1'b0;
        end else begin
            parPhase_q <= parPhase_d;
            aPar_q     <= aPar_d;
            bPar_q     <= bPar_d;
        end
    end
`endif

    // Every output is decoded from registered state only, so a reset shows up immediately.
    assign busy       = (state_q == SHIFT);
    assign bit_valid  = busy;
    assign done       = (state_q == DONE);
    assign load_ready = (state_q == IDLE);

`ifdef LAB03_PAIR_PARITY_EN
    assign a_out      = busy && (parPhase_q ? aPar_q : aShift_q[0]);
    assign b_out      = busy && (parPhase_q ? bPar_q : bShift_q[0]);
    assign first_bit  = busy && !parPhase_q && (bitCnt_q == '0);
    assign last_bit   = busy && parPhase_q;
    assign parity_bit = busy && parPhase_q;
`else
    assign a_out      = busy && aShift_q[0];
    assign b_out      = busy && bShift_q[0];
    assign first_bit  = busy && (bitCnt_q == '0);
    assign last_bit   = busy && (bitCnt_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_lab03_pair_serializer.sv
// Scoreboard bench for lab03_pair_serializer: directed frames first, then randomized loads and resets.
// Build with LAB03_PAIR_PARITY_EN defined to cover the parity-bit variant as well.
module tb_lab03_pair_serializer;

    localparam int W  = 4;
    localparam int BC = 3;
`ifdef LAB03_PAIR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (W + PAR) * BC;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
        logic par;
        logic endFrame;
    } expEntry_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         loadValid = 1'b0;
    logic [W-1:0] aIn = '0;
    logic [W-1:0] bIn = '0;
    logic         loadReady;
    logic         aOut;
    logic         bOut;
    logic         bitValid;
    logic         firstBit;
    logic         lastBit;
    logic         busy;
    logic         done;
`ifdef LAB03_PAIR_PARITY_EN
    logic         parityBit;
`endif

    expEntry_t expQ[$];
    int        edgeCnt = 0;
    int        readyAt = 0;
    int        acceptCnt = 0;
    logic      expDone = 1'b0;
    int        compared = 0;
    int        mismatched = 0;

    lab03_pair_serializer #(
        .WIDTH(W),
        .BIT_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (loadValid),
        .load_ready (loadReady),
        .a_in       (aIn),
        .b_in       (bIn),
        .a_out      (aOut),
        .b_out      (bOut),
        .bit_valid  (bitValid),
        .first_bit  (firstBit),
        .last_bit   (lastBit),
        .busy       (busy),
        .done       (done)
`ifdef LAB03_PAIR_PARITY_EN
        ,
        .parity_bit (parityBit)
`endif
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Reference model: at each rising edge decide whether a load is accepted, using only
    // the frame-length rule (busy for FRAME+2 edges after an accept), and queue the whole
    // expected frame as one entry per clock cycle.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            readyAt = 0;
        end else if (loadValid && edgeCnt >= readyAt) begin
            for (int k = 0; k < W + PAR; k++) begin
                for (int c = 0; c < BC; c++) begin
                    expEntry_t e;
                    if (k < W) begin
                        e.a = aIn[k];
                        e.b = bIn[k];
                    end else begin
                        e.a = ^aIn;
                        e.b = ^bIn;
                    end
                    e.first    = (k == 0);
                    e.last     = (k == W + PAR - 1);
                    e.par      = (k == W);
                    e.endFrame = (k == W + PAR - 1) && (c == BC - 1);
                    expQ.push_back(e);
                end
            end
            readyAt   = edgeCnt + FRAME + 2;
            acceptCnt = acceptCnt + 1;
        end
        edgeCnt = edgeCnt + 1;
    end

    // Single place where comparisons are counted; prints a FAIL line on any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every falling edge compare the DUT against the model. While the queue
    // holds entries the DUT must be shifting and presents exactly the popped bit pair;
    // the cycle after the final entry must carry the done pulse.
    always @(negedge clk) begin
        if (rst) begin
            expDone = 1'b0;
            checkOutput("resetOutputs",
                {24'd0, aOut, bOut, bitValid, firstBit, lastBit, busy, done, loadReady},
                32'h0000_0001);
`ifdef LAB03_PAIR_PARITY_EN
            checkOutput("resetParity", {31'd0, parityBit}, 32'd0);
`endif
        end else begin
            logic expBusy;
            expBusy = (expQ.size() != 0);
            checkOutput("loadReady", {31'd0, loadReady}, {31'd0, (edgeCnt >= readyAt)});
            checkOutput("done", {31'd0, done}, {31'd0, expDone});
            checkOutput("bitValid", {31'd0, bitValid}, {31'd0, expBusy});
            checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
            expDone = 1'b0;
            if (expBusy) begin
                expEntry_t e;
                e = expQ.pop_front();
                checkOutput("bitPair", {28'd0, aOut, bOut, firstBit, lastBit},
                    {28'd0, e.a, e.b, e.first, e.last});
`ifdef LAB03_PAIR_PARITY_EN
                checkOutput("parityBit", {31'd0, parityBit}, {31'd0, e.par});
`endif
                expDone = e.endFrame;
            end else begin
                checkOutput("framingIdle", {30'd0, firstBit, lastBit}, 32'd0);
            end
        end
    end

    // Present one operand pair with load_valid held until the model records the accept;
    // load_valid stays high afterwards so consecutive calls exercise back-to-back frames.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int start;
        aIn       = a;
        bIn       = b;
        loadValid = 1'b1;
        start     = acceptCnt;
        for (int t = 0; t < 4 * FRAME + 8 && acceptCnt == start; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus: directed frames from the test plan, then a randomized soak.
    initial begin
        #1 rst = 1'b1;
        loadValid = 1'b1;
        aIn = 4'b1010;
        bIn = 4'b0110;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(4'b1010, 4'b0110);

        applyStimulus(4'hF, 4'h0);
        applyStimulus(4'b1011, 4'b0110);

        applyStimulus(4'h3, 4'hA);
        loadValid = 1'b0;
        repeat (2 * BC) @(posedge clk);
        #1;
        aIn = 4'h5;
        loadValid = 1'b1;
        @(posedge clk);
        #1;
        loadValid = 1'b0;
        aIn = 4'h0;
        repeat (FRAME + 4) @(posedge clk);
        #1;

        applyStimulus(4'h9, 4'h6);
        applyStimulus(4'h2, 4'hD);
        loadValid = 1'b0;
        repeat (FRAME + 4) @(posedge clk);
        #1;

        applyStimulus(4'hC, 4'h3);
        loadValid = 1'b0;
        repeat (BC) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            if (i % 90 == 45) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            loadValid = ($urandom_range(0, 2) != 0);
            aIn = W'($urandom);
            bIn = W'($urandom);
            @(posedge clk);
            #1;
        end

        loadValid = 1'b0;
        repeat (FRAME + 6) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
